// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM serial receive path: FSM state encodings
// and default frame geometry.
package tdm_demux_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int W_DEF      = 8;

    localparam int CNT_W_DEF  = $clog2(W_DEF);
    localparam int SLOT_W_DEF = $clog2(NUM_CH_DEF);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV   = 2'd1,
        EXPECT = 2'd2
    } state_t;

endpackage

// File: rtl/tdm_demux_if.sv
// Serial link input and parallel frame output of the TDM receiver.
// The master side drives the serial bit stream; the slave side is the receiver.
interface tdm_demux_if
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int W      = W_DEF
);
    localparam int SLOT_W = $clog2(NUM_CH);

    logic                  en;
    logic                  din;
    logic                  sync;
    logic [NUM_CH*W-1:0]   dout;
    logic                  valid;
    logic                  frame_err;
    logic [SLOT_W-1:0]     slot;
    logic                  locked;

    modport master (
        output en, din, sync,
        input  dout, valid, frame_err, slot, locked
    );

    modport slave (
        input  en, din, sync,
        output dout, valid, frame_err, slot, locked
    );

endinterface

// File: rtl/tdm_chan_shift.sv
// One channel slot: W-bit left shift register, serial bit enters at the LSB
// so the first (MSB) bit of the slot ends up at the top.
module tdm_chan_shift
    import tdm_demux_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         shift_en,
    input  logic         sin,
    output logic [W-1:0] q
);

    // Shift one bit in per enabled cycle; cleared asynchronously.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// Receive end of the TDM serial link. Aligns to the frame sync, steers each
// bit into its channel shift register and presents the whole frame in
// parallel once per frame.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | not aligned; waiting for a strobed bit with sync high
// RECV   | inside a frame; bits go to the register of the current slot
// EXPECT | frame just completed; the next strobed bit must carry sync
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int W      = W_DEF
) (
    input  logic       Clock,
    input  logic       Resetn,
    tdm_demux_if.slave bus
);

    localparam int CNT_W  = $clog2(W);
    localparam int SLOT_W = $clog2(NUM_CH);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(W - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [SLOT_W-1:0]     slot;
    logic [NUM_CH*W-1:0]   dout_q;
    logic                  valid_q;
    logic                  frame_err_q;
    logic                  locked_q;

    logic                  start_bit;
    logic                  shift_on;
    logic [SLOT_W-1:0]     shift_slot;
    logic [W-1:0]          chan_q [NUM_CH];
    logic [NUM_CH*W-1:0]   frame_word;

    // A strobed sync bit always opens a new frame in ch0, whatever the state;
    // otherwise bits are only stored while inside a frame.
    assign start_bit  = bus.en & bus.sync;
    assign shift_on   = bus.en & (bus.sync | (state == RECV));
    assign shift_slot = start_bit ? '0 : slot;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tdm_chan_shift #(.W(W)) u_shift (
            .Clock    (Clock),
            .Resetn   (Resetn),
            .shift_en (shift_on && (shift_slot == SLOT_W'(k))),
            .sin      (bus.din),
            .q        (chan_q[k])
        );
    end

    // Complete frame as it will look after this edge: the last channel still
    // needs the bit currently on din.
    always_comb begin
        frame_word = '0;
        for (int k = 0; k < NUM_CH - 1; k++) begin
            frame_word[k*W +: W] = chan_q[k];
        end
        frame_word[(NUM_CH-1)*W +: W] = {chan_q[NUM_CH-1][W-2:0], bus.din};
    end

    // Frame alignment FSM with bit/slot counters and the output latch.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= HUNT;
            bit_cnt     <= '0;
            slot        <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            if (bus.en) begin
                case (state)
                    HUNT: begin
                        if (bus.sync) begin
                            bit_cnt  <= CNT_W'(1);
                            slot     <= '0;
                            state    <= RECV;
                            locked_q <= 1'b1;
                        end
                    end
                    RECV: begin
                        if (bus.sync) begin
                            // RECV never sits on a frame start, so sync here
                            // is a resync: drop the partial frame.
                            frame_err_q <= 1'b1;
                            bit_cnt     <= CNT_W'(1);
                            slot        <= '0;
                        end else if (bit_cnt == CNT_LAST) begin
                            bit_cnt <= '0;
                            if (slot == SLOT_LAST) begin
                                slot    <= '0;
                                dout_q  <= frame_word;
                                valid_q <= 1'b1;
                                state   <= EXPECT;
                            end else begin
                                slot <= slot + SLOT_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    EXPECT: begin
                        if (bus.sync) begin
                            bit_cnt <= CNT_W'(1);
                            slot    <= '0;
                            state   <= RECV;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= HUNT;
                            locked_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.slot      = slot;
    assign bus.locked    = locked_q;

endmodule
